mono_frame_buffer: RTL and testbench
====================================

Name: mono_frame_buffer

Overview:
Consumes the mono sample stream from the stereo-to-mono converter (one-cycle valid strobes, no backpressure). Groups the samples into fixed-length frames in a ping-pong pair of RAM banks. Emits each complete frame as an AXI4-Stream master burst, with TLAST on the final sample, to the downstream FFT/visualizer core. Only complete frames are ever emitted; samples arriving while both banks are occupied are dropped and counted.

Parameters:
DATA_WIDTH, 32, width of mono samples and M_AXIS_TDATA
FRAME_LEN, 256, samples per frame; power of two, >= 4
ADDR_WIDTH, 8, log2(FRAME_LEN); bank address width
DROP_CNT_WIDTH, 16, width of the saturating dropped-sample counter

Ports:
M_AXIS_ACLK  in  1  single clock for the whole block
M_AXIS_ARESET  in  1  synchronous, active-high reset
mono_sample_valid  in  1  one-cycle strobe; mono_sample is captured on this edge
mono_sample  in  DATA_WIDTH  mono sample from the upstream converter
M_AXIS_TVALID  out  1  output beat valid
M_AXIS_TDATA  out  DATA_WIDTH  frame sample
M_AXIS_TLAST  out  1  high on beat FRAME_LEN-1 of each frame
M_AXIS_TREADY  in  1  downstream ready
frame_overflow  out  1  sticky; set on the first dropped sample, cleared only by reset
dropped_samples  out  DROP_CNT_WIDTH  count of dropped samples; saturates at all-ones

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. On any edge with M_AXIS_ARESET=1:
  - M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0, frame_overflow=0, dropped_samples=0.
  - Both banks are marked free; fill bank=0; write address=0; drain FSM=IDLE.
  - Any partial frame or in-flight burst is abandoned. RAM contents are don't-care.
- Fill side (runs on every mono_sample_valid):
  - If the fill bank is free, write the sample at wr_addr and increment wr_addr.
  - On the write at wr_addr=FRAME_LEN-1: mark the bank full, wrap wr_addr to 0, toggle the fill bank.
  - If the (new) fill bank is not free, the sample is dropped. frame_overflow<=1; dropped_samples increments (saturating). wr_addr stays 0.
  - Filling resumes at address 0 with the first valid sample that arrives after the bank has been freed. Partial frames are never emitted.
- Drain FSM; drain bank starts at 0 and alternates strictly:
  - IDLE: if the drain bank is full -> LOAD. Otherwise stay in IDLE.
  - LOAD: RAM read of address 0 is issued -> STREAM. TDATA is registered from the RAM output.
  - STREAM: M_AXIS_TVALID=1.
    - RAM read address = rd_addr+1 when TVALID&&TREADY, else rd_addr. TDATA therefore updates only on a handshake.
    - TLAST = (rd_addr==FRAME_LEN-1).
    - On the handshake with TLAST: mark the drain bank free, toggle the drain bank, TVALID<=0 -> IDLE.
- Latency: if the last sample of a frame is captured at edge k and the drain FSM is IDLE, M_AXIS_TVALID is high after edge k+2. Minimum gap between bursts is 2 idle cycles.
- AXIS rules:
  - TDATA and TLAST are held stable while TVALID && !TREADY.
  - TVALID never drops without a handshake.
  - TVALID does not depend combinationally on TREADY.
- Simultaneous events:
  - If the final drain handshake frees a bank on edge k, a sample on edge k+1 may be written into it. A sample on edge k itself sees the bank still full and is dropped.
  - Fill and drain use different banks, so the write and read ports never conflict on the same bank.
- Width rules:
  - wr_addr and rd_addr are ADDR_WIDTH bits and wrap naturally.
  - Banks are addressed as {bank_bit, addr}: total depth 2*FRAME_LEN, address width ADDR_WIDTH+1.

Decomposition:
- Shared package mono_frame_pkg:
  - Drain FSM state encoding (IDLE, LOAD, STREAM).
  - Default DATA_WIDTH and FRAME_LEN constants, shared with the converter and FFT-side blocks.
- One sub-module, frame_bank_ram:
  - Simple dual-port RAM, depth 2*FRAME_LEN.
  - Write port: synchronous write.
  - Read port: synchronous registered read with one-cycle latency, inferable as block RAM.
  - The fill/drain control logic stays in the top module.

Test Plan:
All scenarios use FRAME_LEN=8, ADDR_WIDTH=3.
1. Reset, TREADY=1, feed 8 samples 0x1..0x8, one every 4 cycles -> TVALID rises 2 edges after the 8th capture; 8 beats of 0x1..0x8; TLAST only on 0x8; dropped_samples=0.
2. Same frame, TREADY toggles 1,0,0,1,... -> TDATA/TLAST stable during stalls; beat order 0x1..0x8 preserved; exactly 8 handshakes.
3. TREADY=1, feed 16 back-to-back samples 0x10..0x1F -> two bursts (0x10..0x17, then 0x18..0x1F); frame_overflow=0.
4. TREADY=0, feed 24 samples 0x1..0x18 -> frame_overflow=1, dropped_samples=8. Then TREADY=1 -> bursts 0x1..0x8 then 0x9..0x10; 0x11..0x18 never appear.
5. Assert M_AXIS_ARESET for 1 cycle during beat 3 of a burst -> TVALID=0 after that edge; counters=0. A following fresh 8-sample frame 0xA0..0xA7 streams correctly.
6. Feed 5 samples, then none for 100 cycles -> TVALID stays 0. Three more samples complete the frame -> burst of all 8 samples in order.

Source files
------------

// File: rtl/mono_frame_pkg.sv
// Shared constants and drain-side state encoding for the mono frame buffer
// and its neighbouring converter / FFT blocks.
package mono_frame_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_FRAME_LEN  = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2
  } drain_state_t;

endpackage

// File: rtl/frame_bank_ram.sv
// Simple dual-port RAM holding both ping-pong frame banks.
// Synchronous write, registered read with one-cycle latency.
module frame_bank_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // The output register doubles as the stream data register, so it clears on reset.
  always_ff @(posedge clk) begin
    if (srst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/mono_frame_buffer.sv
// Collects mono samples into fixed-length frames across two RAM banks and
// streams each complete frame out as an AXI4-Stream burst with TLAST.
module mono_frame_buffer
  import mono_frame_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int FRAME_LEN      = DEFAULT_FRAME_LEN,
  parameter int ADDR_WIDTH     = 8,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      M_AXIS_ACLK,
  input  logic                      M_AXIS_ARESET,
  input  logic                      mono_sample_valid,
  input  logic [DATA_WIDTH-1:0]     mono_sample,
  output logic                      M_AXIS_TVALID,
  output logic [DATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic                      M_AXIS_TLAST,
  input  logic                      M_AXIS_TREADY,
  output logic                      frame_overflow,
  output logic [DROP_CNT_WIDTH-1:0] dropped_samples
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_LEN - 1);

  logic                      full_reg [2];
  logic                      fill_bank_reg;
  logic [ADDR_WIDTH-1:0]     wr_addr_reg;
  logic                      overflow_reg;
  logic [DROP_CNT_WIDTH-1:0] dropped_reg;

  drain_state_t              state_reg;
  logic                      drain_bank_reg;
  logic [ADDR_WIDTH-1:0]     rd_addr_reg;
  logic [ADDR_WIDTH-1:0]     rd_addr_next;
  logic                      tvalid_reg;
  logic                      tlast_reg;

  logic wr_en;
  logic handshake;
  logic fill_done;
  logic drain_done;

  assign wr_en      = mono_sample_valid && !full_reg[fill_bank_reg];
  assign handshake  = tvalid_reg && M_AXIS_TREADY;
  assign fill_done  = wr_en && (wr_addr_reg == LAST_ADDR);
  assign drain_done = handshake && tlast_reg;

  // Read address advances only on a handshake, so TDATA holds through stalls.
  always_comb begin
    rd_addr_next = rd_addr_reg;
    if (state_reg == LOAD) begin
      rd_addr_next = '0;
    end else if (handshake) begin
      rd_addr_next = rd_addr_reg + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank_state
      always_ff @(posedge M_AXIS_ACLK) begin
        if (M_AXIS_ARESET) begin
          full_reg[gi] <= 1'b0;
        end else if (fill_done && (fill_bank_reg == 1'(gi))) begin
          full_reg[gi] <= 1'b1;
        end else if (drain_done && (drain_bank_reg == 1'(gi))) begin
          full_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      fill_bank_reg <= 1'b0;
      wr_addr_reg   <= '0;
      overflow_reg  <= 1'b0;
      dropped_reg   <= '0;
    end else if (mono_sample_valid) begin
      if (wr_en) begin
        wr_addr_reg <= wr_addr_reg + 1'b1;
        if (fill_done) begin
          fill_bank_reg <= ~fill_bank_reg;
        end
      end else begin
        overflow_reg <= 1'b1;
        if (dropped_reg != '1) begin
          dropped_reg <= dropped_reg + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      state_reg      <= IDLE;
      drain_bank_reg <= 1'b0;
      rd_addr_reg    <= '0;
      tvalid_reg     <= 1'b0;
      tlast_reg      <= 1'b0;
    end else begin
      rd_addr_reg <= rd_addr_next;
      case (state_reg)
        IDLE: begin
          if (full_reg[drain_bank_reg]) begin
            state_reg <= LOAD;
          end
        end
        LOAD: begin
          tvalid_reg <= 1'b1;
          tlast_reg  <= 1'b0;
          state_reg  <= STREAM;
        end
        STREAM: begin
          if (handshake) begin
            if (tlast_reg) begin
              tvalid_reg     <= 1'b0;
              tlast_reg      <= 1'b0;
              drain_bank_reg <= ~drain_bank_reg;
              state_reg      <= IDLE;
            end else begin
              tlast_reg <= (rd_addr_next == LAST_ADDR);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  frame_bank_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH + 1)
  ) u_ram (
    .clk     (M_AXIS_ACLK),
    .srst    (M_AXIS_ARESET),
    .wr_en   (wr_en),
    .wr_addr ({fill_bank_reg, wr_addr_reg}),
    .wr_data (mono_sample),
    .rd_addr ({drain_bank_reg, rd_addr_next}),
    .rd_data (M_AXIS_TDATA)
  );

  assign M_AXIS_TVALID   = tvalid_reg;
  assign M_AXIS_TLAST    = tlast_reg;
  assign frame_overflow  = overflow_reg;
  assign dropped_samples = dropped_reg;

endmodule

// File: tb/tb_mono_frame_buffer.sv
// Scoreboard bench for mono_frame_buffer with 8-sample frames: stimulus pushes
// expected beats, a negedge monitor pops and compares every AXIS handshake.
module tb_mono_frame_buffer;

  localparam int DW = 32;
  localparam int FL = 8;
  localparam int AW = 3;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          areset;
  logic          sample_valid;
  logic [DW-1:0] sample;
  logic          tvalid;
  logic [DW-1:0] tdata;
  logic          tlast;
  logic          tready;
  logic          overflow;
  logic [CW-1:0] dropped;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int checks     = 0;
  int failures   = 0;
  int hs_count   = 0;
  int ready_mode = 1;  // 0: low, 1: high, 2: pattern 1,0,0

  initial forever #5 clk = ~clk;

  mono_frame_buffer #(
    .DATA_WIDTH     (DW),
    .FRAME_LEN      (FL),
    .ADDR_WIDTH     (AW),
    .DROP_CNT_WIDTH (CW)
  ) dut (
    .M_AXIS_ACLK       (clk),
    .M_AXIS_ARESET     (areset),
    .mono_sample_valid (sample_valid),
    .mono_sample       (sample),
    .M_AXIS_TVALID     (tvalid),
    .M_AXIS_TDATA      (tdata),
    .M_AXIS_TLAST      (tlast),
    .M_AXIS_TREADY     (tready),
    .frame_overflow    (overflow),
    .dropped_samples   (dropped)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic feed(input logic [DW-1:0] d, input bit push, input bit last);
    beat_t b;
    @(posedge clk); #1;
    sample_valid = 1'b1;
    sample       = d;
    if (push) begin
      b.data = d;
      b.last = last;
      exp_q.push_back(b);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      sample_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input int max_cycles, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout actual=%0d_pending required=0", name, exp_q.size());
    end
    repeat (6) @(negedge clk);
  endtask

  // TREADY driver
  initial begin
    int phase = 0;
    tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       tready = 1'b0;
        1:       tready = 1'b1;
        default: tready = (phase == 0);
      endcase
      phase = (phase + 1) % 3;
    end
  end

  // Monitor: pops the scoreboard on each handshake and checks stall stability
  initial begin
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    logic          prev_last  = 1'b0;
    beat_t         e;
    forever begin
      @(negedge clk);
      if (areset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_tvalid", 64'(tvalid), 64'd1);
          check("stall_tdata", 64'(tdata), 64'(prev_data));
          check("stall_tlast", 64'(tlast), 64'(prev_last));
        end
        if (tvalid && tready) begin
          hs_count++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat actual=0x%0h required=no_beat", tdata);
          end else begin
            e = exp_q.pop_front();
            $display("beat data=0x%0h last=%0b expected_data=0x%0h expected_last=%0b",
                     tdata, tlast, e.data, e.last);
            check("beat_data", 64'(tdata), 64'(e.data));
            check("beat_last", 64'(tlast), 64'(e.last));
          end
        end
        prev_stall = tvalid && !tready;
        prev_data  = tdata;
        prev_last  = tlast;
      end
    end
  end

  initial begin
    int base;
    int n;
    bit saw_valid;

    areset       = 1'b1;
    sample_valid = 1'b0;
    sample       = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_tvalid", 64'(tvalid), 64'd0);
    check("reset_tlast", 64'(tlast), 64'd0);
    check("reset_tdata", 64'(tdata), 64'd0);
    check("reset_overflow", 64'(overflow), 64'd0);
    check("reset_dropped", 64'(dropped), 64'd0);
    @(posedge clk); #1;
    areset = 1'b0;

    // 1: spaced samples, latency from the final capture
    ready_mode = 1;
    for (int i = 1; i <= 7; i++) begin
      feed(DW'(i), 1'b1, 1'b0);
      idle(3);
    end
    feed(DW'(8), 1'b1, 1'b1);
    idle(1);
    @(negedge clk);
    check("t1_latency_k", 64'(tvalid), 64'd0);
    @(negedge clk);
    check("t1_latency_k1", 64'(tvalid), 64'd0);
    @(negedge clk);
    check("t1_latency_k2", 64'(tvalid), 64'd1);
    wait_drain(100, "t1");
    check("t1_dropped", 64'(dropped), 64'd0);

    // 2: same frame with stalling downstream
    ready_mode = 2;
    base = hs_count;
    for (int i = 1; i <= 8; i++) feed(DW'(i), 1'b1, i == 8);
    idle(1);
    wait_drain(200, "t2");
    check("t2_handshakes", 64'(hs_count - base), 64'd8);
    ready_mode = 1;

    // 3: two back-to-back frames
    for (int i = 0; i < 16; i++) feed(DW'(32'h10 + i), 1'b1, (i == 7) || (i == 15));
    idle(1);
    wait_drain(200, "t3");
    check("t3_overflow", 64'(overflow), 64'd0);

    // 4: downstream blocked, third frame dropped
    ready_mode = 0;
    idle(2);
    for (int i = 1; i <= 24; i++) feed(DW'(i), i <= 16, (i == 8) || (i == 16));
    idle(2);
    check("t4_overflow", 64'(overflow), 64'd1);
    check("t4_dropped", 64'(dropped), 64'd8);
    ready_mode = 1;
    wait_drain(200, "t4");
    check("t4_dropped_after", 64'(dropped), 64'd8);

    // 5: reset in the middle of a burst
    base = hs_count;
    for (int i = 0; i < 8; i++) feed(DW'(32'h31 + i), 1'b1, i == 7);
    idle(1);
    n = 0;
    while (hs_count < base + 3 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    check("t5_reach_beat3", 64'(hs_count >= base + 3), 64'd1);
    areset = 1'b1;
    @(posedge clk); #1;
    areset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("t5_tvalid", 64'(tvalid), 64'd0);
    check("t5_tlast", 64'(tlast), 64'd0);
    check("t5_overflow", 64'(overflow), 64'd0);
    check("t5_dropped", 64'(dropped), 64'd0);
    for (int i = 0; i < 8; i++) feed(DW'(32'hA0 + i), 1'b1, i == 7);
    idle(1);
    wait_drain(100, "t5");

    // 6: partial frame must not be emitted
    for (int i = 0; i < 5; i++) feed(DW'(32'h61 + i), 1'b1, 1'b0);
    idle(1);
    saw_valid = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (tvalid) saw_valid = 1'b1;
    end
    check("t6_no_partial", 64'(saw_valid), 64'd0);
    for (int i = 5; i < 8; i++) feed(DW'(32'h61 + i), 1'b1, i == 7);
    idle(1);
    wait_drain(100, "t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
